// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment display blocks: default bank geometry,
// the anode "off" level and the code driven while a digit is dark.
package disp_pkg;

   localparam int DEFAULT_NUM_DIGITS = 4;
   localparam int DEFAULT_DIGIT_W    = 4;

   // Common-anode enables are active-low, so an unlit anode is a one
   localparam logic AN_OFF_BIT = 1'b1;

   // Digit code presented to the segment decoder while a digit is blanked
   localparam int BLANK_CODE = 0;

endpackage

// File: rtl/scan_prescaler.sv
// Refresh prescaler: counts enabled cycles 0..REFRESH_DIV-1 and flags the
// terminal count as a single-cycle tick. The count holds while disabled so
// scanning resumes exactly where it stopped.
module scan_prescaler #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] count;

   assign tick = enable && (count == LAST_COUNT);

   // Free-running count while enabled, wrapping on the terminal count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (enable) begin
         if (count == LAST_COUNT) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed driver for a common-anode 7-segment bank. Scans the digit
// codes one per refresh period, snapshots the inputs at each frame start so a
// frame never mixes old and new values, and applies leading-zero blanking and
// per-digit blinking. All outputs are registered together.
module digit_scan_mux
   import disp_pkg::*;
#(
   parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
   parameter int DIGIT_W      = DEFAULT_DIGIT_W,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64,
   localparam int SEL_W       = $clog2(NUM_DIGITS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
   input  logic                          blank_lz,
   input  logic [NUM_DIGITS-1:0]         blink_mask,
   output logic [NUM_DIGITS-1:0]         AN,
   output logic [SEL_W-1:0]              AN_SEL,
   output logic [DIGIT_W-1:0]            digit_BCD,
   output logic                          frame_done
);

   localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SEL_W-1:0]      LAST_IDX   = SEL_W'(NUM_DIGITS - 1);
   localparam logic [BC_W-1:0]       LAST_FRAME = BC_W'(BLINK_FRAMES - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = {NUM_DIGITS{AN_OFF_BIT}};
   localparam logic [DIGIT_W-1:0]    BLANK      = DIGIT_W'(BLANK_CODE);

   logic                          tick;
   logic                          wrap;
   logic [SEL_W-1:0]              idx;
   logic [SEL_W-1:0]              next_idx;
   logic [NUM_DIGITS*DIGIT_W-1:0] snapshot;
   logic [NUM_DIGITS*DIGIT_W-1:0] view;
   logic [DIGIT_W-1:0]            view_digits [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]         nonzero_from;
   logic [BC_W-1:0]               blink_cnt;
   logic [BC_W-1:0]               next_blink_cnt;
   logic                          blink_phase;
   logic                          next_blink_phase;
   logic                          lit;
   logic                          next_lit;
   logic [DIGIT_W-1:0]            next_code;
   logic [NUM_DIGITS-1:0]         next_an;

   scan_prescaler #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (tick)
   );

   // The scan index doubles as the digit-select output
   assign AN_SEL = idx;

   // Next scan position, frame wrap detection and blink frame counting;
   // on a wrap the fresh inputs are viewed directly so digit 0 uses them
   always_comb begin
      wrap             = tick && (idx == LAST_IDX);
      next_idx         = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      view             = wrap ? digits_in : snapshot;
      next_blink_cnt   = blink_cnt;
      next_blink_phase = blink_phase;
      if (wrap) begin
         if (blink_cnt == LAST_FRAME) begin
            next_blink_cnt   = '0;
            next_blink_phase = ~blink_phase;
         end else begin
            next_blink_cnt = blink_cnt + 1'b1;
         end
      end
   end

   // Split the viewed codes into digits and prefix-OR them from the top
   // down, so nonzero_from[i] says some digit at or above i is non-zero
   always_comb begin : lz_scan
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         view_digits[i] = view[i*DIGIT_W +: DIGIT_W];
      end
      nonzero_from = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         acc             = acc | (|view_digits[i]);
         nonzero_from[i] = acc;
      end
   end

   // Decide whether the digit about to be shown is lit, and what it drives
   always_comb begin
      next_lit = 1'b1;
      if (next_blink_phase && blink_mask[next_idx]) begin
         next_lit = 1'b0;
      end
      if (blank_lz && (next_idx != '0) && !nonzero_from[next_idx]) begin
         next_lit = 1'b0;
      end
      next_code = next_lit ? view_digits[next_idx] : BLANK;
      next_an   = next_lit ? ~(NUM_DIGITS'(1) << next_idx) : AN_ALL_OFF;
   end

   // Scan state and registered outputs; a tick updates everything at once,
   // otherwise the anodes follow enable using the stored lit decision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= LAST_IDX;
         snapshot    <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         lit         <= 1'b0;
         AN          <= AN_ALL_OFF;
         digit_BCD   <= BLANK;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= wrap;
         if (tick) begin
            idx         <= next_idx;
            lit         <= next_lit;
            AN          <= next_an;
            digit_BCD   <= next_code;
            blink_cnt   <= next_blink_cnt;
            blink_phase <= next_blink_phase;
            if (wrap) begin
               snapshot <= digits_in;
            end
         end else if (!enable) begin
            AN <= AN_ALL_OFF;
         end else begin
            AN <= lit ? ~(NUM_DIGITS'(1) << idx) : AN_ALL_OFF;
         end
      end
   end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux: directed scenarios followed by randomized traffic,
// every cycle compared against a model that derives the display state from
// the number of enabled cycles since reset.
module tb_digit_scan_mux;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int RD = 4;
   localparam int BF = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [15:0]   digits_in;
   logic          blank_lz;
   logic [3:0]    blink_mask;
   logic [3:0]    an;
   logic [1:0]    an_sel;
   logic [3:0]    digit_bcd;
   logic          frame_done;

   int checks = 0;
   int errors = 0;

   int          m_e;
   logic [15:0] m_snap;
   logic [3:0]  m_an;
   logic [1:0]  m_sel;
   logic [3:0]  m_bcd;
   logic        m_fd;
   logic        m_lit;

   digit_scan_mux #(
      .NUM_DIGITS   (N),
      .DIGIT_W      (DW),
      .REFRESH_DIV  (RD),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .digits_in  (digits_in),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
      .AN         (an),
      .AN_SEL     (an_sel),
      .digit_BCD  (digit_bcd),
      .frame_done (frame_done)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_e    = 0;
      m_snap = '0;
      m_an   = 4'hF;
      m_sel  = 2'd3;
      m_bcd  = 4'h0;
      m_fd   = 1'b0;
      m_lit  = 1'b0;
   endtask

   // Display state as a function of enabled-cycle count: every RD-th enabled
   // cycle is a scan step; step t shows digit (t-1) mod N of frame (t-1)/N+1
   task automatic model_edge();
      int t;
      int ix;
      int f;
      int phase;
      logic [15:0] upper;
      if (rst) begin
         model_reset();
         return;
      end
      m_fd = 1'b0;
      if (!enable) begin
         m_an = 4'hF;
         return;
      end
      m_e++;
      if (m_e % RD == 0) begin
         t  = m_e / RD;
         ix = (t - 1) % N;
         if (ix == 0) begin
            m_snap = digits_in;
            m_fd   = 1'b1;
         end
         f     = (t - 1) / N + 1;
         phase = (f / BF) % 2;
         upper = m_snap >> (ix * DW);
         m_lit = !((phase == 1 && blink_mask[ix]) || (blank_lz && ix > 0 && upper == 16'h0));
         m_sel = 2'(ix);
         m_bcd = m_lit ? upper[3:0] : 4'h0;
      end
      for (int d = 0; d < N; d++) begin
         m_an[d] = !(m_lit && d == int'(m_sel));
      end
   endtask

   task automatic check_output();
      check_val("an", 32'(an), 32'(m_an));
      check_val("an_sel", 32'(an_sel), 32'(m_sel));
      check_val("digit_bcd", 32'(digit_bcd), 32'(m_bcd));
      check_val("frame_done", 32'(frame_done), 32'(m_fd));
   endtask

   task automatic apply_stimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         #1;
         check_output();
      end
   endtask

   initial begin
      bit found;
      rst        = 1'b1;
      enable     = 1'b1;
      digits_in  = 16'h4321;
      blank_lz   = 1'b0;
      blink_mask = 4'b0000;
      model_reset();
      #2;
      check_val("reset_an", 32'(an), 32'hF);
      check_val("reset_sel", 32'(an_sel), 32'd3);
      check_val("reset_bcd", 32'(digit_bcd), 32'd0);
      check_val("reset_fd", 32'(frame_done), 32'd0);
      apply_stimulus(2);
      rst = 1'b0;

      $display("[TB] first frame after reset");
      apply_stimulus(4);
      check_val("first_an", 32'(an), 32'hE);
      check_val("first_bcd", 32'(digit_bcd), 32'd1);
      check_val("first_fd", 32'(frame_done), 32'd1);
      apply_stimulus(4);
      check_val("d1_an", 32'(an), 32'hD);
      check_val("d1_bcd", 32'(digit_bcd), 32'd2);

      $display("[TB] mid-frame input change");
      apply_stimulus(2);
      digits_in = 16'h8765;
      apply_stimulus(2);
      check_val("old_d2_an", 32'(an), 32'hB);
      check_val("old_d2_bcd", 32'(digit_bcd), 32'd3);
      apply_stimulus(4);
      check_val("old_d3_an", 32'(an), 32'h7);
      check_val("old_d3_bcd", 32'(digit_bcd), 32'd4);
      apply_stimulus(4);
      check_val("new_d0_bcd", 32'(digit_bcd), 32'd5);
      check_val("new_d0_fd", 32'(frame_done), 32'd1);
      apply_stimulus(12);

      $display("[TB] leading-zero blanking");
      blank_lz  = 1'b1;
      digits_in = 16'h0050;
      apply_stimulus(4);
      check_val("lz_d0_an", 32'(an), 32'hE);
      check_val("lz_d0_bcd", 32'(digit_bcd), 32'd0);
      apply_stimulus(4);
      check_val("lz_d1_bcd", 32'(digit_bcd), 32'd5);
      apply_stimulus(4);
      check_val("lz_d2_an", 32'(an), 32'hF);
      check_val("lz_d2_bcd", 32'(digit_bcd), 32'd0);
      apply_stimulus(4);
      digits_in = 16'h0000;
      apply_stimulus(4);
      check_val("zero_d0_an", 32'(an), 32'hE);
      apply_stimulus(4);
      check_val("zero_d1_an", 32'(an), 32'hF);
      apply_stimulus(8);

      $display("[TB] blinking");
      blank_lz   = 1'b0;
      digits_in  = 16'h4321;
      blink_mask = 4'b0100;
      apply_stimulus(12);
      check_val("blink_lit_an", 32'(an), 32'hB);
      check_val("blink_lit_bcd", 32'(digit_bcd), 32'd3);
      apply_stimulus(16);
      check_val("blink_dark_an", 32'(an), 32'hF);
      check_val("blink_dark_bcd", 32'(digit_bcd), 32'd0);
      apply_stimulus(32);

      $display("[TB] enable pause");
      blink_mask = 4'b0000;
      found = 1'b0;
      for (int k = 0; k < 64 && !found; k++) begin
         apply_stimulus(1);
         if (m_sel == 2'd2 && m_e % RD == 1) found = 1'b1;
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("[TB] FAIL pause_reach observed=0 expected=1");
      end
      enable = 1'b0;
      apply_stimulus(1);
      check_val("pause_an", 32'(an), 32'hF);
      check_val("pause_sel", 32'(an_sel), 32'd2);
      apply_stimulus(9);
      enable = 1'b1;
      apply_stimulus(1);
      check_val("resume_an", 32'(an), 32'hB);
      apply_stimulus(1);
      check_val("resume_hold_sel", 32'(an_sel), 32'd2);
      apply_stimulus(1);
      check_val("resume_step_sel", 32'(an_sel), 32'd3);
      apply_stimulus(6);

      $display("[TB] asynchronous reset mid-frame");
      #2;
      rst = 1'b1;
      #1;
      check_val("async_an", 32'(an), 32'hF);
      check_val("async_sel", 32'(an_sel), 32'd3);
      check_val("async_fd", 32'(frame_done), 32'd0);
      model_reset();
      apply_stimulus(1);
      rst = 1'b0;
      apply_stimulus(4);
      check_val("restart_an", 32'(an), 32'hE);
      check_val("restart_bcd", 32'(digit_bcd), 32'd1);
      check_val("restart_fd", 32'(frame_done), 32'd1);

      $display("[TB] randomized traffic");
      for (int k = 0; k < 3000; k++) begin
         digits_in  = 16'($urandom);
         blank_lz   = 1'($urandom_range(0, 1));
         blink_mask = 4'($urandom);
         enable     = ($urandom_range(0, 9) != 0);
         rst        = ($urandom_range(0, 299) == 0);
         apply_stimulus(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
